// File: rtl/ioctl_upload_responder.sv
// ioctl_upload_responder: serves hps_io upload reads from a core byte RAM,
// arbitrating for the RAM and appending a running checksum byte.
module ioctl_upload_responder #(
    parameter int ADDR_W  = 10,
    parameter int LEN     = 256,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_sys,
    input  logic              Reset_I,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ram_req,
    input  logic              ram_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              upload_done
);

    localparam int IDX_W = ADDR_W + 1;
    localparam logic [24:0]      LEN_A = 25'(LEN);
    localparam logic [IDX_W-1:0] LEN_I = IDX_W'(LEN);
    localparam logic [1:0]       LAT_C = 2'(RAM_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_READ,
        S_LAT,
        S_HOLD
    } state_t;

    state_t            state_q;
    logic [24:0]       addr_q;
    logic [1:0]        cnt_q;
    logic [7:0]        sum_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        din_q;
    logic              wait_q;
    logic              req_q;
    logic              rd_q;
    logic [ADDR_W-1:0] raddr_q;
    logic              done_q;

    logic [7:0]        sum_d;
    logic [IDX_W-1:0]  idx_d;
    logic              in_order;
    logic              complete;
    logic              capture;

    // Checksum bookkeeping: next sum/index and whether this capture counts.
    always_comb begin
        sum_d    = sum_q + ram_q;
        idx_d    = idx_q + 1'b1;
        in_order = (addr_q[IDX_W-1:0] == idx_q);
        complete = (idx_q == LEN_I);
        capture  = (state_q == S_LAT) && (cnt_q == LAT_C);
    end

    // Running sum of in-order payload bytes; re-seeded whenever no session.
    always_ff @(posedge clk_sys) begin
        if (!Reset_I) begin
            sum_q <= 8'h00;
            idx_q <= '0;
        end else if (!ioctl_upload) begin
            sum_q <= 8'h00;
            idx_q <= '0;
        end else if (capture && in_order) begin
            sum_q <= sum_d;
            idx_q <= idx_d;
        end
    end

    // Request FSM with registered bus and RAM-side outputs.
    always_ff @(posedge clk_sys) begin
        if (!Reset_I) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            din_q   <= 8'h00;
            wait_q  <= 1'b0;
            req_q   <= 1'b0;
            rd_q    <= 1'b0;
            raddr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            if (!ioctl_upload) begin
                state_q <= S_IDLE;
                wait_q  <= 1'b0;
                req_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE, S_HOLD: begin
                        if (ioctl_rd) begin
                            addr_q  <= ioctl_addr;
                            wait_q  <= 1'b1;
                            req_q   <= 1'b1;
                            state_q <= S_ARB;
                        end
                    end
                    S_ARB: begin
                        if (addr_q >= LEN_A) begin
                            if (addr_q == LEN_A) begin
                                din_q <= complete ? sum_q : 8'h00;
                            end else begin
                                din_q <= 8'hFF;
                            end
                            done_q  <= (addr_q == LEN_A) && complete;
                            wait_q  <= 1'b0;
                            state_q <= S_HOLD;
                        end else if (ram_gnt) begin
                            rd_q    <= 1'b1;
                            raddr_q <= addr_q[ADDR_W-1:0];
                            state_q <= S_READ;
                        end
                    end
                    S_READ: begin
                        cnt_q   <= 2'd1;
                        state_q <= S_LAT;
                    end
                    S_LAT: begin
                        if (cnt_q == LAT_C) begin
                            din_q   <= ram_q;
                            wait_q  <= 1'b0;
                            state_q <= S_HOLD;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ioctl_din   = din_q;
    assign ioctl_wait  = wait_q;
    assign ram_req     = req_q;
    assign ram_addr    = raddr_q;
    assign ram_rd      = rd_q;
    assign upload_done = done_q;

endmodule
